fifo_noc2nic: RTL and testbench

Receive-side flit buffer between the NoC input link and the NIC master (wishbone) side; the counterpart of the NIC-to-NoC transmit path. Captures incoming flits into one FIFO per virtual channel, tracks complete packets per VC, and delivers flits to the NIC on request. For every flit drained it returns a credit to the upstream router, and for every tail drained a VC-free indication.

---
 rtl/fifo_noc2nic.sv | 129 ++++++++++++
 tb/tb_fifo_noc2nic.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_noc2nic.sv
// Receive-side flit buffer: one circular FIFO per VC, fed from the NoC link and drained by the NIC.
// Each pop returns a credit upstream, and each pop of a tail also releases the VC.
module fifo_noc2nic #(
   parameter int FLIT_WIDTH    = 32,
   parameter int N_TOT_OF_VC   = 6,
   parameter int N_BITS_VC_ID  = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int N_BITS_DEPTH  = 2,
   parameter int VC_ID_LSB     = 0,
   parameter int FLIT_TYPE_LSB = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLIT_WIDTH-1:0]  in_link_i,
   input  logic                   is_valid_i,
   output logic [N_TOT_OF_VC-1:0] credit_signal_o,
   output logic [N_TOT_OF_VC-1:0] free_signal_o,
   input  logic [N_TOT_OF_VC-1:0] rd_en_i,
   output logic [FLIT_WIDTH-1:0]  out_link_o,
   output logic                   is_valid_o,
   output logic [N_TOT_OF_VC-1:0] vc_not_empty_o,
   output logic [N_TOT_OF_VC-1:0] packet_ready_o,
   output logic                   overflow_err_o
);

   localparam int N_BITS_CNT = N_BITS_DEPTH + 1;

   logic [FLIT_WIDTH-1:0]   mem_r     [N_TOT_OF_VC][FIFO_DEPTH];
   logic [N_BITS_DEPTH-1:0] wr_ptr_r  [N_TOT_OF_VC];
   logic [N_BITS_DEPTH-1:0] rd_ptr_r  [N_TOT_OF_VC];
   logic [N_BITS_CNT-1:0]   count_r   [N_TOT_OF_VC];
   logic [N_BITS_CNT-1:0]   pkt_cnt_r [N_TOT_OF_VC];

   logic [N_BITS_VC_ID-1:0] wr_vc_s;
   logic [N_BITS_VC_ID-1:0] pop_vc_s;
   logic                    pop_req_s;
   logic                    pop_s;
   logic                    wr_tail_s;
   logic                    pop_tail_s;
   logic                    vc_in_range_s;
   logic                    wr_ok_s;
   logic                    drop_s;
   logic [FLIT_WIDTH-1:0]   front_s;
   logic [N_TOT_OF_VC-1:0]  push_vec_s;
   logic [N_TOT_OF_VC-1:0]  pop_vec_s;

   // Decode write target, pick the lowest requested VC, and decide accept/drop.
   always_comb begin
      wr_vc_s   = in_link_i[VC_ID_LSB +: N_BITS_VC_ID];
      wr_tail_s = in_link_i[FLIT_TYPE_LSB + 1];
      pop_req_s = 1'b0;
      pop_vc_s  = {N_BITS_VC_ID{1'b0}};
      // Scanning downward leaves the lowest set bit as the winner.
      for (int i = N_TOT_OF_VC - 1; i >= 0; i--) begin
         if (rd_en_i[i]) begin
            pop_req_s = 1'b1;
            pop_vc_s  = N_BITS_VC_ID'(i);
         end else begin
            pop_req_s = pop_req_s;
         end
      end
      // Emptiness is judged on stored state only, so a same-cycle write never bypasses.
      pop_s         = pop_req_s && (count_r[pop_vc_s] != N_BITS_CNT'(0));
      front_s       = mem_r[pop_vc_s][rd_ptr_r[pop_vc_s]];
      pop_tail_s    = front_s[FLIT_TYPE_LSB + 1];
      vc_in_range_s = (int'(wr_vc_s) < N_TOT_OF_VC);
      wr_ok_s       = is_valid_i && vc_in_range_s &&
                      ((count_r[wr_vc_s] != N_BITS_CNT'(FIFO_DEPTH)) ||
                       (pop_s && (pop_vc_s == wr_vc_s)));
      drop_s        = is_valid_i && !wr_ok_s;
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
         push_vec_s[v] = wr_ok_s && (wr_vc_s == N_BITS_VC_ID'(v));
         pop_vec_s[v]  = pop_s && (pop_vc_s == N_BITS_VC_ID'(v));
      end
   end

   // Flit storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_vc_s][wr_ptr_r[wr_vc_s]] <= in_link_i;
      end
   end

   // Per-VC pointers, occupancy and packet counters, plus the registered NIC/router outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < N_TOT_OF_VC; v++) begin
            wr_ptr_r[v]  <= {N_BITS_DEPTH{1'b0}};
            rd_ptr_r[v]  <= {N_BITS_DEPTH{1'b0}};
            count_r[v]   <= {N_BITS_CNT{1'b0}};
            pkt_cnt_r[v] <= {N_BITS_CNT{1'b0}};
         end
         out_link_o      <= {FLIT_WIDTH{1'b0}};
         is_valid_o      <= 1'b0;
         credit_signal_o <= {N_TOT_OF_VC{1'b0}};
         free_signal_o   <= {N_TOT_OF_VC{1'b0}};
         overflow_err_o  <= 1'b0;
      end else begin
         for (int v = 0; v < N_TOT_OF_VC; v++) begin
            if (push_vec_s[v]) wr_ptr_r[v] <= wr_ptr_r[v] + N_BITS_DEPTH'(1);
            if (pop_vec_s[v])  rd_ptr_r[v] <= rd_ptr_r[v] + N_BITS_DEPTH'(1);
            case ({push_vec_s[v], pop_vec_s[v]})
               2'b10:   count_r[v] <= count_r[v] + N_BITS_CNT'(1);
               2'b01:   count_r[v] <= count_r[v] - N_BITS_CNT'(1);
               default: count_r[v] <= count_r[v];
            endcase
            case ({push_vec_s[v] && wr_tail_s, pop_vec_s[v] && pop_tail_s})
               2'b10:   pkt_cnt_r[v] <= pkt_cnt_r[v] + N_BITS_CNT'(1);
               2'b01:   pkt_cnt_r[v] <= pkt_cnt_r[v] - N_BITS_CNT'(1);
               default: pkt_cnt_r[v] <= pkt_cnt_r[v];
            endcase
         end
         out_link_o      <= pop_s ? front_s : out_link_o;
         is_valid_o      <= pop_s;
         credit_signal_o <= pop_vec_s;
         free_signal_o   <= pop_tail_s ? pop_vec_s : {N_TOT_OF_VC{1'b0}};
         overflow_err_o  <= overflow_err_o | drop_s;
      end
   end

   // Status flags decoded straight from the counter registers.
   always_comb begin
      for (int v = 0; v < N_TOT_OF_VC; v++) begin
         vc_not_empty_o[v] = (count_r[v] != N_BITS_CNT'(0));
         packet_ready_o[v] = (pkt_cnt_r[v] != N_BITS_CNT'(0));
      end
   end

endmodule

// File: tb/tb_fifo_noc2nic.sv
// Scoreboard bench for fifo_noc2nic: a per-VC queue model predicts every pop result and status flag.
module tb_fifo_noc2nic;

   localparam int FW = 32;
   localparam int NV = 6;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst;
   logic [FW-1:0] in_link_i;
   logic          is_valid_i;
   logic [NV-1:0] credit_signal_o;
   logic [NV-1:0] free_signal_o;
   logic [NV-1:0] rd_en_i;
   logic [FW-1:0] out_link_o;
   logic          is_valid_o;
   logic [NV-1:0] vc_not_empty_o;
   logic [NV-1:0] packet_ready_o;
   logic          overflow_err_o;

   fifo_noc2nic dut (
      .clk             (clk),
      .rst             (rst),
      .in_link_i       (in_link_i),
      .is_valid_i      (is_valid_i),
      .credit_signal_o (credit_signal_o),
      .free_signal_o   (free_signal_o),
      .rd_en_i         (rd_en_i),
      .out_link_o      (out_link_o),
      .is_valid_o      (is_valid_o),
      .vc_not_empty_o  (vc_not_empty_o),
      .packet_ready_o  (packet_ready_o),
      .overflow_err_o  (overflow_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic [FW-1:0] flit;
      logic [NV-1:0] credit;
      logic [NV-1:0] free;
   } exp_t;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [FW-1:0] mq [NV][$];
   exp_t          exp_q [$];
   logic [FW-1:0] last_out;
   logic          err_model;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int vc, input logic [1:0] ftype, input int payload);
      logic [FW-1:0] f;
      f = {FW{1'b0}};
      f[2:0] = 3'(vc);
      f[4:3] = ftype;
      f[FW-1:5] = 27'(payload);
      return f;
   endfunction

   task automatic check_status();
      logic [NV-1:0] ne;
      logic [NV-1:0] pr;
      ne = '0;
      pr = '0;
      for (int v = 0; v < NV; v++) begin
         ne[v] = (mq[v].size() != 0);
         for (int k = 0; k < mq[v].size(); k++) begin
            if (mq[v][k][4]) pr[v] = 1'b1;
         end
      end
      check_val("vc_not_empty", 64'(vc_not_empty_o), 64'(ne));
      check_val("packet_ready", 64'(packet_ready_o), 64'(pr));
      check_val("overflow_err", 64'(overflow_err_o), 64'(err_model));
   endtask

   // One clock: predict, drive, then compare the registered results 1 time unit after the edge.
   task automatic step(input logic valid, input logic [FW-1:0] flit, input logic [NV-1:0] rd);
      int   pv;
      int   wv;
      logic pop_ok;
      logic acc;
      exp_t e;
      exp_t got;
      pv = -1;
      for (int i = NV - 1; i >= 0; i--) if (rd[i]) pv = i;
      pop_ok = (pv >= 0) && (mq[pv].size() != 0);
      wv = int'(flit[2:0]);
      acc = valid && (wv < NV) && ((mq[wv].size() < DEPTH) || (pop_ok && pv == wv));
      e = '0;
      if (pop_ok) begin
         e.valid = 1'b1;
         e.flit = mq[pv].pop_front();
         e.credit[pv] = 1'b1;
         e.free[pv] = e.flit[4];
      end
      if (acc) mq[wv].push_back(flit);
      if (valid && !acc) err_model = 1'b1;
      exp_q.push_back(e);
      in_link_i = flit;
      is_valid_i = valid;
      rd_en_i = rd;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_val("scoreboard_underrun", 64'd1, 64'd0);
      end else begin
         got = exp_q.pop_front();
         if (got.valid) last_out = got.flit;
         check_val("is_valid", 64'(is_valid_o), 64'(got.valid));
         check_val("out_link", 64'(out_link_o), 64'(last_out));
         check_val("credit", 64'(credit_signal_o), 64'(got.credit));
         check_val("free", 64'(free_signal_o), 64'(got.free));
      end
      check_status();
   endtask

   task automatic do_reset(input logic valid, input logic [FW-1:0] flit, input logic [NV-1:0] rd);
      rst = 1'b1;
      in_link_i = flit;
      is_valid_i = valid;
      rd_en_i = rd;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int v = 0; v < NV; v++) mq[v].delete();
      exp_q.delete();
      last_out = '0;
      err_model = 1'b0;
      check_val("rst_is_valid", 64'(is_valid_o), 64'd0);
      check_val("rst_out_link", 64'(out_link_o), 64'd0);
      check_val("rst_credit", 64'(credit_signal_o), 64'd0);
      check_val("rst_free", 64'(free_signal_o), 64'd0);
      check_status();
   endtask

   initial begin
      rst = 1'b0;
      in_link_i = '0;
      is_valid_i = 1'b0;
      rd_en_i = '0;
      last_out = '0;
      err_model = 1'b0;
      do_reset(1'b0, '0, '0);

      // Packet on VC 2, then drain it.
      step(1'b1, mk(2, 2'b01, 100), '0);
      check_val("vc2_not_empty", 64'(vc_not_empty_o), 64'h04);
      step(1'b1, mk(2, 2'b00, 101), '0);
      step(1'b1, mk(2, 2'b10, 102), '0);
      check_val("vc2_packet_ready", 64'(packet_ready_o), 64'h04);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 6'h04);
      check_val("vc2_drained", 64'(vc_not_empty_o), 64'h00);

      // Overflow on VC 0, then full-plus-pop acceptance after a clean reset.
      for (int i = 0; i < 4; i++) step(1'b1, mk(0, 2'b00, 200 + i), '0);
      step(1'b1, mk(0, 2'b11, 204), '0);
      check_val("vc0_overflow", 64'(overflow_err_o), 64'd1);
      step(1'b0, '0, '0);
      do_reset(1'b0, '0, '0);
      for (int i = 0; i < 4; i++) step(1'b1, mk(0, 2'b00, 300 + i), '0);
      step(1'b1, mk(0, 2'b11, 304), 6'h01);
      check_val("vc0_full_pop_no_err", 64'(overflow_err_o), 64'd0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 6'h01);

      // Out-of-range VC id and pop of an empty VC.
      step(1'b1, mk(7, 2'b11, 400), 6'h08);
      check_val("vc7_overflow", 64'(overflow_err_o), 64'd1);

      // Multi-bit rd_en and same-cycle write+pop on an empty VC.
      do_reset(1'b0, '0, '0);
      step(1'b1, mk(1, 2'b11, 500), '0);
      step(1'b1, mk(3, 2'b11, 501), '0);
      step(1'b0, '0, 6'h0A);
      check_val("multi_rd_credit", 64'(credit_signal_o), 64'h02);
      step(1'b1, mk(5, 2'b11, 502), 6'h20);
      check_val("no_bypass", 64'(is_valid_o), 64'd0);
      step(1'b0, '0, 6'h20);
      step(1'b0, '0, 6'h08);

      // Interleaved head-tail traffic across all VCs with a reset in the middle.
      for (int k = 0; k < 240; k++) begin
         logic [NV-1:0] rd;
         if (k % 7 == 3) rd = 6'($urandom_range(0, 63));
         else rd = 6'(1 << ((k + 5) % NV));
         if (k == 120) do_reset(1'b1, mk(k % NV, 2'b11, 1000 + k), rd);
         else step(1'b1, mk(k % NV, 2'b11, 1000 + k), rd);
      end
      for (int k = 0; k < 6 * DEPTH; k++) step(1'b0, '0, 6'(1 << (k % NV)));
      check_val("final_empty", 64'(vc_not_empty_o), 64'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
